// File: rtl/cpu_cu.sv
// cpu_cu: RISC16 control unit FSM (fetch, decode, exec/mem); optional single-step via CU_STEP_EN.
// 3 cycles per instruction with mem_rdy=1; each mem_rdy=0 cycle in FETCH or MEM stalls one cycle.
module cpu_cu #(
    parameter int IR_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CU_STEP_EN
    input  logic             step,
`endif
    input  logic [IR_W-1:0]  ir,
    input  logic             zero,
    input  logic             mem_rdy,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic             we,
    output logic             s_sel,
    output logic [3:0]       alu_op,
    output logic             addr_sel,
    output logic             mem_we,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
`ifdef CU_STEP_EN
    localparam logic [2:0] S_STEP_WAIT = 3'd6;
    localparam logic [2:0] S_AFTER     = S_STEP_WAIT;
`else
    localparam logic [2:0] S_AFTER     = S_FETCH;
`endif

    localparam logic [3:0] OP_LD  = 4'hA;
    localparam logic [3:0] OP_ST  = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_JZ  = 4'hD;
    localparam logic [3:0] OP_JNZ = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic [3:0]       opcode;
    logic             is_alu;
    logic             unused_ir;

    assign opcode    = ir[IR_W-1 -: 4];
    assign is_alu    = (opcode >= 4'h1) && (opcode <= 4'h9);
    assign unused_ir = ^ir[IR_W-5:0];
    assign instr_cnt = cnt_q;

`ifdef CU_STEP_EN
    logic step_q, step_d;
    logic step_rise;
    assign step_d    = step;
    assign step_rise = step && !step_q;
`endif

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        we       = 1'b0;
        s_sel    = 1'b0;
        alu_op   = 4'h0;
        addr_sel = 1'b0;
        mem_we   = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_rdy) begin
                    ir_ld   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                pc_inc = 1'b1;
                if (opcode == OP_LD || opcode == OP_ST) begin
                    state_d = S_MEM;
                end else if (opcode == OP_HLT) begin
                    // HLT retires here, on its way into HALT
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op = opcode;
                we     = is_alu;
                case (opcode)
                    OP_JMP:  pc_ld = 1'b1;
                    OP_JZ:   pc_ld = zero;
                    OP_JNZ:  pc_ld = !zero;
                    default: pc_ld = 1'b0;
                endcase
                retire  = 1'b1;
                state_d = S_AFTER;
            end
            S_MEM: begin
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_ST);
                if (mem_rdy) begin
                    we      = (opcode == OP_LD);
                    s_sel   = (opcode == OP_LD);
                    retire  = 1'b1;
                    state_d = S_AFTER;
                end
            end
            S_HALT: halted = 1'b1;
`ifdef CU_STEP_EN
            S_STEP_WAIT: begin
                if (step_rise) state_d = S_FETCH;
            end
`endif
            default: state_d = S_RESET;
        endcase
        cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
`ifdef CU_STEP_EN
            step_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef CU_STEP_EN
            step_q  <= step_d;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_cu.sv
// Bench for cpu_cu: instruction-timeline model queues per-cycle expected outputs; one negedge compare process.
// A second instance with a 4-bit counter exercises counter wrap within a short run.
`timescale 1ns/1ps
module tb_cpu_cu;

    typedef struct packed {
        logic        ir_ld;
        logic        pc_inc;
        logic        pc_ld;
        logic        we;
        logic        s_sel;
        logic [3:0]  alu_op;
        logic        addr_sel;
        logic        mem_we;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        zero;
    logic        mem_rdy;
    logic        ir_ld, pc_inc, pc_ld, we, s_sel, addr_sel, mem_we, halted;
    logic [3:0]  alu_op;
    logic [15:0] instr_cnt;
    logic        w_ir_ld, w_pc_inc, w_pc_ld, w_we, w_s_sel, w_addr_sel, w_mem_we, w_halted;
    logic [3:0]  w_alu_op;
    logic [3:0]  w_cnt;
`ifdef CU_STEP_EN
    logic        step = 1'b0;
    logic        m_wait = 1'b0;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   m_cnt    = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    cpu_cu #(.IR_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
`ifdef CU_STEP_EN
        .step(step),
`endif
        .ir(ir), .zero(zero), .mem_rdy(mem_rdy),
        .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .we(we), .s_sel(s_sel),
        .alu_op(alu_op), .addr_sel(addr_sel), .mem_we(mem_we), .halted(halted),
        .instr_cnt(instr_cnt)
    );

    cpu_cu #(.IR_W(16), .CNT_W(4)) u_wrap (
        .clk(clk), .rst(rst),
`ifdef CU_STEP_EN
        .step(step),
`endif
        .ir(ir), .zero(zero), .mem_rdy(mem_rdy),
        .ir_ld(w_ir_ld), .pc_inc(w_pc_inc), .pc_ld(w_pc_ld), .we(w_we), .s_sel(w_s_sel),
        .alu_op(w_alu_op), .addr_sel(w_addr_sel), .mem_we(w_mem_we), .halted(w_halted),
        .instr_cnt(w_cnt)
    );

    function automatic exp_t ev(input logic i_ld, input logic p_inc, input logic p_ld,
                                input logic w_e, input logic ss, input logic [3:0] op,
                                input logic as, input logic mw, input logic h);
        exp_t e;
        e.ir_ld = i_ld; e.pc_inc = p_inc; e.pc_ld = p_ld; e.we = w_e; e.s_sel = ss;
        e.alu_op = op; e.addr_sel = as; e.mem_we = mw; e.halted = h;
        e.cnt = m_cnt[15:0];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp_v);
        end
    endtask

    // Drive one cycle's inputs just after the edge; the expectation is checked at the following negedge.
    task automatic cyc(input logic r, input logic rdy, input exp_t e, input logic push);
        rst = r;
        mem_rdy = rdy;
        if (push) q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_seq();
        cyc(1'b0, 1'b0, '0, 1'b0);
        m_cnt = 0;
`ifdef CU_STEP_EN
        m_wait = 1'b0;
        step = 1'b0;
`endif
        cyc(1'b1, 1'b1, ev(0,0,0,0,0,4'h0,0,0,0), 1'b1);
    endtask

    task automatic release_step();
`ifdef CU_STEP_EN
        if (m_wait) begin
            step = 1'b0;
            cyc(1'b1, 1'b0, ev(0,0,0,0,0,4'h0,0,0,0), 1'b1);
            step = 1'b1;
            cyc(1'b1, 1'b0, ev(0,0,0,0,0,4'h0,0,0,0), 1'b1);
            m_wait = 1'b0;
        end
`endif
    endtask

    task automatic mark_retired();
        m_cnt++;
`ifdef CU_STEP_EN
        m_wait = 1'b1;
`endif
    endtask

    task automatic run_instr(input logic [15:0] instr, input int fwait, input int mwait);
        logic [3:0] op;
        logic       alu, jmp, ld, st;
        op  = instr[15:12];
        alu = (op >= 4'h1) && (op <= 4'h9);
        ld  = (op == 4'hA);
        st  = (op == 4'hB);
        jmp = (op == 4'hC) || (op == 4'hD && zero) || (op == 4'hE && !zero);
        release_step();
        ir = instr;
        repeat (fwait) cyc(1'b1, 1'b0, ev(0,0,0,0,0,4'h0,0,0,0), 1'b1);
        cyc(1'b1, 1'b1, ev(1,0,0,0,0,4'h0,0,0,0), 1'b1);
        cyc(1'b1, 1'b1, ev(0,1,0,0,0,4'h0,0,0,0), 1'b1);
        if (op == 4'hF) begin
            m_cnt++;
        end else if (ld || st) begin
            repeat (mwait) cyc(1'b1, 1'b0, ev(0,0,0,0,0,4'h0,1,st,0), 1'b1);
            cyc(1'b1, 1'b1, ev(0,0,0,ld,ld,4'h0,1,st,0), 1'b1);
            mark_retired();
        end else begin
            cyc(1'b1, 1'b1, ev(0,0,jmp,alu,0,op,0,0,0), 1'b1);
            mark_retired();
        end
    endtask

    always @(negedge clk) begin
        exp_t e, a, ew, aw;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {ir_ld, pc_inc, pc_ld, we, s_sel, alu_op, addr_sel, mem_we, halted, instr_cnt};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, a, e);
            end
            ew = e;
            ew.cnt = {12'h0, e.cnt[3:0]};
            aw = {w_ir_ld, w_pc_inc, w_pc_ld, w_we, w_s_sel, w_alu_op, w_addr_sel, w_mem_we,
                  w_halted, 12'h0, w_cnt};
            checks++;
            if (aw !== ew) begin
                failures++;
                $display("FAIL wrap_outputs t=%0t: got %h expected %h", $time, aw, ew);
            end
            checks++;
            if ((pc_inc && pc_ld) || (we && mem_we)) begin
                failures++;
                $display("FAIL strobe_exclusive t=%0t: pc_inc=%b pc_ld=%b we=%b mem_we=%b",
                         $time, pc_inc, pc_ld, we, mem_we);
            end
        end
    end

    initial begin
        rst = 1'b0; ir = 16'h0000; zero = 1'b0; mem_rdy = 1'b0;
        @(posedge clk);
        #1;
        reset_seq();
        chk("reset_cnt", {16'h0, instr_cnt}, 32'd0);
        chk("reset_halted", {31'h0, halted}, 32'd0);

        run_instr(16'h1123, 0, 0);
        chk("add_cnt", {16'h0, instr_cnt}, 32'd1);
        run_instr(16'hA045, 0, 2);
        chk("ld_cnt", {16'h0, instr_cnt}, 32'd2);
        zero = 1'b1; run_instr(16'hD010, 0, 0);
        zero = 1'b0; run_instr(16'hD010, 0, 0);
        zero = 1'b1; run_instr(16'hE010, 1, 0);
        zero = 1'b0; run_instr(16'hE010, 0, 0);
        run_instr(16'hC0F0, 0, 0);
        run_instr(16'h2345, 2, 0);
        run_instr(16'h9001, 0, 0);
        run_instr(16'h0000, 0, 0);
        run_instr(16'hB012, 0, 1);
        run_instr(16'hA045, 0, 0);
        chk("mix_cnt", {16'h0, instr_cnt}, 32'd12);

        // Store interrupted by reset while mem_we is asserted
        release_step();
        ir = 16'hB012;
        cyc(1'b1, 1'b1, ev(1,0,0,0,0,4'h0,0,0,0), 1'b1);
        cyc(1'b1, 1'b1, ev(0,1,0,0,0,4'h0,0,0,0), 1'b1);
        cyc(1'b0, 1'b0, ev(0,0,0,0,0,4'h0,1,1,0), 1'b1);
        m_cnt = 0;
`ifdef CU_STEP_EN
        m_wait = 1'b0;
        step = 1'b0;
`endif
        cyc(1'b1, 1'b0, ev(0,0,0,0,0,4'h0,0,0,0), 1'b1);
        chk("rst_mid_mem_cnt", {16'h0, instr_cnt}, 32'd0);
        chk("rst_mid_mem_we", {31'h0, mem_we}, 32'd0);
        run_instr(16'h0000, 1, 0);

        for (int i = 0; i < 16; i++) run_instr(16'h0000, 0, 0);
        chk("wrap_cnt", {28'h0, w_cnt}, 32'h1);
        chk("nop_cnt", {16'h0, instr_cnt}, 32'd17);

        run_instr(16'hF000, 0, 0);
        repeat (20) cyc(1'b1, 1'b1, ev(0,0,0,0,0,4'h0,0,0,1), 1'b1);
        chk("halt_flag", {31'h0, halted}, 32'd1);
        chk("halt_cnt", {16'h0, instr_cnt}, 32'd18);

`ifdef CU_STEP_EN
        reset_seq();
        run_instr(16'h0000, 0, 0);
        step = 1'b0;
        cyc(1'b1, 1'b0, ev(0,0,0,0,0,4'h0,0,0,0), 1'b1);
        step = 1'b1;
        cyc(1'b1, 1'b0, ev(0,0,0,0,0,4'h0,0,0,0), 1'b1);
        m_wait = 1'b0;
        run_instr(16'h0000, 0, 0);
        repeat (6) cyc(1'b1, 1'b1, ev(0,0,0,0,0,4'h0,0,0,0), 1'b1);
        chk("step_held_cnt", {16'h0, instr_cnt}, 32'd2);
        for (int i = 0; i < 3; i++) run_instr(16'h0000, 0, 0);
        chk("step_pulse_cnt", {16'h0, instr_cnt}, 32'd5);
`endif

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
